// File: rtl/led_pulse_stretch.sv
// led_pulse_stretch: per-channel LED pulse stretcher.
// Each 0->1 event on event_in starts a visible on-phase of ON_TICKS ticks,
// followed by a forced off-gap of OFF_TICKS ticks. At most one further event
// is remembered while busy and replayed when the gap ends. A single shared
// prescaler generates the tick, so all channels share tick phase.
module led_pulse_stretch #(
    parameter int    WIDTH         = 4,
    parameter string POLARITY      = "LOW",
    parameter int    TIMEOUT       = 50000,
    parameter int    TIMEOUT_WIDTH = 16,
    parameter int    ON_TICKS      = 50,
    parameter int    OFF_TICKS     = 20,
    parameter int    TICK_WIDTH    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] event_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ON   = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    // Active-high output when POLARITY is "HIGH", otherwise active-low.
    localparam logic ACTIVE_HIGH = (POLARITY == "HIGH");

    localparam logic [TIMEOUT_WIDTH-1:0] PRESCALE_LAST = TIMEOUT_WIDTH'(TIMEOUT - 1);
    localparam logic [TICK_WIDTH-1:0]    ON_LOAD       = TICK_WIDTH'(ON_TICKS);
    localparam logic [TICK_WIDTH-1:0]    OFF_LOAD      = TICK_WIDTH'(OFF_TICKS);
    localparam logic [TICK_WIDTH-1:0]    LAST_TICK     = TICK_WIDTH'(1);

    logic [TIMEOUT_WIDTH-1:0] prescale;
    logic                     tick;
    logic [WIDTH-1:0]         event_prev;
    logic [WIDTH-1:0]         evt;
    logic [WIDTH-1:0]         pending;
    logic [1:0]               state [WIDTH];
    logic [TICK_WIDTH-1:0]    count [WIDTH];

    assign tick = (prescale == PRESCALE_LAST);
    assign evt  = event_in & ~event_prev;

    // Shared prescaler: counts 0..TIMEOUT-1 and wraps on the tick cycle.
    always_ff @(posedge clk) begin
        if (reset || tick) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

    // Previous-sample register; also loads during reset so a level already
    // high at reset release is not seen as a rising edge.
    always_ff @(posedge clk) begin
        event_prev <= event_in;
    end

    // Per-channel IDLE/ON/GAP sequencing with one-deep event memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            data_out <= {WIDTH{~ACTIVE_HIGH}};
            for (int unsigned i = 0; i < WIDTH; i++) begin
                state[i] <= IDLE;
                count[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                data_out[i] <= (state[i] == ON) ~^ ACTIVE_HIGH;
                case (state[i])
                    IDLE: begin
                        if (evt[i]) begin
                            state[i] <= ON;
                            count[i] <= ON_LOAD;
                        end
                    end
                    ON: begin
                        if (evt[i]) begin
                            pending[i] <= 1'b1;
                        end
                        if (tick) begin
                            if (count[i] == LAST_TICK) begin
                                state[i] <= GAP;
                                count[i] <= OFF_LOAD;
                            end else begin
                                count[i] <= count[i] - 1'b1;
                            end
                        end
                    end
                    GAP: begin
                        if (tick && count[i] == LAST_TICK) begin
                            // An event arriving on the exit tick counts as pending.
                            if (pending[i] || evt[i]) begin
                                state[i] <= ON;
                                count[i] <= ON_LOAD;
                            end else begin
                                state[i] <= IDLE;
                                count[i] <= '0;
                            end
                            pending[i] <= 1'b0;
                        end else begin
                            if (evt[i]) begin
                                pending[i] <= 1'b1;
                            end
                            if (tick) begin
                                count[i] <= count[i] - 1'b1;
                            end
                        end
                    end
                    default: begin
                        state[i]   <= IDLE;
                        count[i]   <= '0;
                        pending[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Busy whenever the channel is not idle.
    always_comb begin
        busy = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            busy[i] = (state[i] != IDLE);
        end
    end

endmodule

// File: tb/tb_led_pulse_stretch.sv
// tb_led_pulse_stretch: directed plus randomized stimulus against a timeline
// model that predicts each pulse's ON/GAP end times arithmetically.
module tb_led_pulse_stretch;

    localparam int W   = 4;
    localparam int T   = 4;
    localparam int ONT = 3;
    localparam int OFT = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] event_in;
    logic [W-1:0] data_lo, busy_lo, data_hi, busy_hi;

    always #5 clk = ~clk;

    led_pulse_stretch #(
        .WIDTH(W), .POLARITY("LOW"), .TIMEOUT(T), .TIMEOUT_WIDTH(4),
        .ON_TICKS(ONT), .OFF_TICKS(OFT), .TICK_WIDTH(4)
    ) dut_lo (
        .clk(clk), .reset(reset), .event_in(event_in),
        .data_out(data_lo), .busy(busy_lo)
    );

    led_pulse_stretch #(
        .WIDTH(W), .POLARITY("HIGH"), .TIMEOUT(T), .TIMEOUT_WIDTH(4),
        .ON_TICKS(ONT), .OFF_TICKS(OFT), .TICK_WIDTH(4)
    ) dut_hi (
        .clk(clk), .reset(reset), .event_in(event_in),
        .data_out(data_hi), .busy(busy_hi)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: k is the index of the next non-reset edge since reset.
    int           k;
    int           on_end  [W];
    int           gap_end [W];
    bit           active  [W];
    bit           pend    [W];
    bit           prev_on [W];
    logic [W-1:0] prev_in;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s at k=%0d: observed %h expected %h", tag, k, observed, expected);
        end
    endtask

    // Start a pulse at edge k0: ON ends on the ONT-th tick strictly after k0.
    task automatic start_pulse(input int ch, input int k0);
        int first;
        first       = k0 + 1 + ((T - 1 - ((k0 + 1) % T)) % T);
        on_end[ch]  = first + (ONT - 1) * T;
        gap_end[ch] = on_end[ch] + OFT * T;
        active[ch]  = 1'b1;
    endtask

    task automatic step(input logic rst, input logic [W-1:0] ev);
        logic [W-1:0] exp_busy, exp_lo, exp_hi;
        bit e;
        reset    = rst;
        event_in = ev;
        @(posedge clk);
        exp_busy = '0;
        exp_lo   = '1;
        if (rst) begin
            for (int ch = 0; ch < W; ch++) begin
                active[ch]  = 1'b0;
                pend[ch]    = 1'b0;
                prev_on[ch] = 1'b0;
            end
            k = 0;
        end else begin
            for (int ch = 0; ch < W; ch++) begin
                e = ev[ch] & ~prev_in[ch];
                exp_lo[ch] = ~prev_on[ch];
                if (active[ch] && k == gap_end[ch]) begin
                    if (pend[ch] || e) start_pulse(ch, k);
                    else active[ch] = 1'b0;
                    pend[ch] = 1'b0;
                end else if (!active[ch]) begin
                    if (e) start_pulse(ch, k);
                end else if (e) begin
                    pend[ch] = 1'b1;
                end
                exp_busy[ch] = active[ch];
                prev_on[ch]  = active[ch] && (k < on_end[ch]);
            end
            k++;
        end
        prev_in = ev;
        exp_hi  = ~exp_lo;
        #1;
        check("busy_lo", 32'(busy_lo), 32'(exp_busy));
        check("data_lo", 32'(data_lo), 32'(exp_lo));
        check("busy_hi", 32'(busy_hi), 32'(exp_busy));
        check("data_hi", 32'(data_hi), 32'(exp_hi));
    endtask

    initial begin
        logic [W-1:0] ev;
        bit           found;
        k       = 0;
        prev_in = '0;
        for (int ch = 0; ch < W; ch++) begin
            active[ch] = 1'b0; pend[ch] = 1'b0; prev_on[ch] = 1'b0;
            on_end[ch] = 0; gap_end[ch] = 0;
        end

        // Reset with ch2 held high across release: no pulse.
        repeat (3) step(1'b1, 4'b0100);
        repeat (10) step(1'b0, 4'b0100);

        // ch0: pulse, second pulse during ON, third absorbed.
        step(1'b0, 4'b0101);
        repeat (3) step(1'b0, 4'b0100);
        step(1'b0, 4'b0101);
        step(1'b0, 4'b0100);
        step(1'b0, 4'b0101);
        // ch2 drops then rises and holds: exactly one pulse.
        repeat (2) step(1'b0, 4'b0000);
        repeat (60) step(1'b0, 4'b0100);

        // ch1: event coincident with GAP-exit tick.
        step(1'b0, 4'b0010);
        found = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (k == gap_end[1]) begin
                found = 1'b1;
                break;
            end
            step(1'b0, 4'b0000);
        end
        if (!found) begin
            n_fail++;
            $display("FAIL gap_exit_wait: observed timeout expected gap-exit edge");
        end
        step(1'b0, 4'b0010);
        repeat (40) step(1'b0, 4'b0000);

        // ch3: reset for one cycle mid-ON aborts the pulse.
        step(1'b0, 4'b1000);
        repeat (3) step(1'b0, 4'b0000);
        step(1'b1, 4'b0000);
        repeat (40) step(1'b0, 4'b0000);

        // Randomized traffic with occasional resets.
        ev = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int ch = 0; ch < W; ch++) begin
                if ($urandom_range(0, 5) == 0) ev[ch] = ~ev[ch];
            end
            step(($urandom_range(0, 299) == 0), ev);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pulse_stretch.md
LED_PULSE_STRETCH -- requirements
Module: led_pulse_stretch

Interface
REQ-001 SHALL provide parameter WIDTH, default 4: number of independent output channels.
REQ-002 SHALL provide parameter POLARITY, default "LOW": output active level, either "LOW" (active-low LEDs) or "HIGH".
REQ-003 SHALL provide parameter TIMEOUT, default 50000: clock cycles per tick (1 ms at 50 MHz).
REQ-004 SHALL provide parameter TIMEOUT_WIDTH, default 16: prescaler counter width, with TIMEOUT <= 2^TIMEOUT_WIDTH.
REQ-005 SHALL provide parameter ON_TICKS, default 50: minimum visible on-time in ticks, legal range >= 1.
REQ-006 SHALL provide parameter OFF_TICKS, default 20: forced off-gap in ticks between stretched pulses, legal range >= 1.
REQ-007 SHALL provide parameter TICK_WIDTH, default 8: per-channel tick counter width, holding max(ON_TICKS, OFF_TICKS).
REQ-008 SHALL provide port clk, input, 1 bit: single clock for all logic.
REQ-009 SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-010 SHALL provide port event_in, input, WIDTH bits: active-high, clk-synchronous event request per channel, either a pulse or a level.
REQ-011 SHALL provide port data_out, output, WIDTH bits: stretched drive per channel at POLARITY level.
REQ-012 SHALL provide port busy, output, WIDTH bits: high while the channel is not IDLE.

Function
REQ-013 SHALL run one shared prescaler that counts 0..TIMEOUT-1, wraps to 0, and asserts an internal tick for one cycle when the count equals TIMEOUT-1.
REQ-014 SHALL register event_in each cycle and define an event on channel i as event_in[i]=1 while the previous sample was 0.
REQ-015 SHALL give each channel an FSM with states IDLE, ON, GAP, a tick down-counter and a pending flag.
REQ-016 IDLE: on an event, SHALL go to ON next cycle and load the counter with ON_TICKS.
REQ-017 ON: on each tick, SHALL decrement the counter; on a tick with counter==1, SHALL go to GAP and load OFF_TICKS.
REQ-018 GAP: on each tick, SHALL decrement the counter; on a tick with counter==1, SHALL go to ON with ON_TICKS if pending=1 and clear pending, else go to IDLE.
REQ-019 An event in ON or GAP SHALL set pending (one pending at most; further events are absorbed) and SHALL NOT extend or restart the current phase.
REQ-020 An event in the same cycle as the GAP-exit tick SHALL be treated as pending, so the channel goes to ON and pending ends 0.
REQ-021 An event in the same cycle as the ON-exit tick SHALL set pending, and the channel SHALL still enter GAP.
REQ-022 The internal on-signal SHALL be 1 in state ON only.
REQ-023 data_out[i] SHALL be ~on when POLARITY="LOW" and on when POLARITY="HIGH", and SHALL be registered.
REQ-024 First data_out change after an IDLE event SHALL occur exactly 1 cycle after the event sample edge.
REQ-025 Because the first tick is partial, ON duration SHALL be in [(ON_TICKS-1)*TIMEOUT+1, ON_TICKS*TIMEOUT] cycles, and GAP duration SHALL be exactly OFF_TICKS*TIMEOUT cycles.
REQ-026 busy[i] SHALL be 1 in ON or GAP, and 0 in IDLE.
REQ-027 Channels SHALL be fully independent, differing only in tick phase, which is shared.
REQ-028 A held-high event_in level SHALL produce exactly one stretched pulse; a new pulse requires a 0->1 transition.

Reset
REQ-029 While reset=1, SHALL force prescaler=0, all FSMs=IDLE, counters=0, pending=0, busy=0, and data_out to the inactive level (all 1 for "LOW").
REQ-030 While reset=1, the previous-sample register SHALL load event_in, so a level already high at reset release is not an event.
REQ-031 Reset asserted mid-ON or mid-GAP SHALL abort the pulse and take effect on the next clk edge, with no residual pending.

Verification (TIMEOUT=4, ON_TICKS=3, OFF_TICKS=2, WIDTH=4, POLARITY="LOW")
REQ-032 Single 1-cycle pulse on event_in[0] from IDLE -> data_out[0]=0 from the next cycle for 9..12 cycles, then busy[0] high for 8 more cycles, then IDLE; other channels stay 1.
REQ-033 Second pulse on ch0 during ON -> after ON and an 8-cycle GAP, a second ON follows; a third pulse in the same window adds nothing.
REQ-034 Event on ch1 coincident with its GAP-exit tick -> ch1 enters ON directly, with no IDLE cycle and pending=0.
REQ-035 event_in[2] held high across reset release -> no pulse; drop to 0 then raise -> exactly one pulse.
REQ-036 reset=1 for 1 cycle during ch3 ON -> next cycle data_out[3]=1 and busy[3]=0, with no later pulse.
REQ-037 POLARITY="HIGH" rerun of REQ-032 -> identical timing with data_out inverted (idle 0, active 1).
